muldiv_seq_unit: RTL

- Parametrised multi-cycle multiply/divide unit for the bus-based CPU datapath.
- Replaces single-cycle MUL/DIV in the ALU path.
- Takes operand A (from bus) and operand B (from RY), iterates one bit per cycle, and delivers a 2*WIDTH result split into z_hi/z_lo for capture into ZHI/ZLO (later moved to HI/LO).
- Control unit starts it with a pulse and waits for done.

---
 rtl/muldiv_seq_unit.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq_unit.sv
// Multi-cycle multiply/divide unit that resolves one bit per clock: Booth (signed) or shift-add
// (unsigned) multiply, and restoring divide on magnitudes. Optional macro MULDIV_DIVZERO_EN.
module muldiv_seq_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             op_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
`ifdef MULDIV_DIVZERO_EN
    output logic             div_zero,
`endif
    output logic [WIDTH-1:0] z_hi,
    output logic [WIDTH-1:0] z_lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned AW    = WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   opd_q, opd_d;
    logic               qm1_q, qm1_d;
    logic               div_q, div_d;
    logic               sgn_q, sgn_d;
    logic               rneg_q, rneg_d;
    logic               qneg_q, qneg_d;
    logic               armed_q, armed_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   z_hi_q, z_hi_d;
    logic [WIDTH-1:0]   z_lo_q, z_lo_d;
`ifdef MULDIV_DIVZERO_EN
    logic               div_zero_q, div_zero_d;
`endif

    logic [AW-1:0]      a_ext;
    logic [AW-1:0]      mul_term;
    logic [AW-1:0]      mul_sum;
    logic [AW-1:0]      div_shift;
    logic               div_ge;
    logic [AW-1:0]      div_rem;
    logic [AW-1:0]      step_acc;
    logic [WIDTH-1:0]   step_lo;
    logic               step_qm1;
    logic               a_neg;
    logic               b_neg;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return (~x) + WIDTH'(1);
    endfunction

    // One iteration of the multiply or divide datapath
    always_comb begin
        a_ext    = {sgn_q & opd_q[WIDTH-1], opd_q};
        mul_term = '0;
        if (sgn_q) begin
            case ({lo_q[0], qm1_q})
                2'b01:   mul_term = a_ext;
                2'b10:   mul_term = (~a_ext) + AW'(1);
                default: mul_term = '0;
            endcase
        end else if (lo_q[0]) begin
            mul_term = a_ext;
        end
        mul_sum   = acc_q + mul_term;
        div_shift = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opd_q});
        div_rem   = div_ge ? (div_shift - {1'b0, opd_q}) : div_shift;
        if (div_q) begin
            step_acc = div_rem;
            step_lo  = {lo_q[WIDTH-2:0], div_ge};
            step_qm1 = 1'b0;
        end else begin
            step_acc = {sgn_q & mul_sum[WIDTH], mul_sum[WIDTH:1]};
            step_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
            step_qm1 = lo_q[0];
        end
    end

    // Next-state, operand capture and result update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        opd_d   = opd_q;
        qm1_d   = qm1_q;
        div_d   = div_q;
        sgn_d   = sgn_q;
        rneg_d  = rneg_q;
        qneg_d  = qneg_q;
        armed_d = 1'b1;
        z_hi_d  = z_hi_q;
        z_lo_d  = z_lo_q;
`ifdef MULDIV_DIVZERO_EN
        div_zero_d = div_zero_q;
`endif
        a_neg   = is_signed & op_a[WIDTH-1];
        b_neg   = is_signed & op_b[WIDTH-1];

        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start && armed_q) begin
                    state_d = S_RUN;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    acc_d   = '0;
                    qm1_d   = 1'b0;
                    div_d   = op_div;
                    sgn_d   = is_signed;
                    if (op_div) begin
                        lo_d   = a_neg ? neg_w(op_a) : op_a;
                        opd_d  = b_neg ? neg_w(op_b) : op_b;
                        rneg_d = a_neg;
                        // A zero divisor keeps the all-ones quotient unsigned
                        qneg_d = (a_neg ^ b_neg) & (op_b != '0);
                    end else begin
                        lo_d   = op_b;
                        opd_d  = op_a;
                        rneg_d = 1'b0;
                        qneg_d = 1'b0;
                    end
`ifdef MULDIV_DIVZERO_EN
                    if (op_div && (op_b == '0)) begin
                        state_d    = S_DONE;
                        z_hi_d     = op_a;
                        z_lo_d     = '1;
                        div_zero_d = 1'b1;
                    end
`endif
                end
            end
            S_RUN: begin
                acc_d = step_acc;
                lo_d  = step_lo;
                qm1_d = step_qm1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    z_hi_d  = rneg_q ? neg_w(step_acc[WIDTH-1:0]) : step_acc[WIDTH-1:0];
                    z_lo_d  = qneg_q ? neg_w(step_lo) : step_lo;
`ifdef MULDIV_DIVZERO_EN
                    div_zero_d = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            lo_q       <= '0;
            opd_q      <= '0;
            qm1_q      <= 1'b0;
            div_q      <= 1'b0;
            sgn_q      <= 1'b0;
            rneg_q     <= 1'b0;
            qneg_q     <= 1'b0;
            armed_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            z_hi_q     <= '0;
            z_lo_q     <= '0;
`ifdef MULDIV_DIVZERO_EN
            div_zero_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            lo_q       <= lo_d;
            opd_q      <= opd_d;
            qm1_q      <= qm1_d;
            div_q      <= div_d;
            sgn_q      <= sgn_d;
            rneg_q     <= rneg_d;
            qneg_q     <= qneg_d;
            armed_q    <= armed_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            z_hi_q     <= z_hi_d;
            z_lo_q     <= z_lo_d;
`ifdef MULDIV_DIVZERO_EN
            div_zero_q <= div_zero_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign z_hi = z_hi_q;
    assign z_lo = z_lo_q;
`ifdef MULDIV_DIVZERO_EN
    assign div_zero = div_zero_q;
`endif

endmodule
